// File: rtl/tree_broadcaster_pkg.sv
// Shared types and size helpers for the tree broadcaster: FSM state encoding,
// level-count derivation and the default pixel type.
package tree_bcast_pkg;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam int unsigned DEF_ADDER_DATASIZE = 16;
   typedef logic [DEF_ADDER_DATASIZE-1:0] pix_t;

   function automatic int unsigned clog2f(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Number of 2x expansion levels for a grid of the given side.
   function automatic int unsigned log2n_f(input int unsigned side);
      return clog2f(side);
   endfunction

   // Width of a field able to hold 0..LOG2N.
   function automatic int unsigned lvl_w_f(input int unsigned side);
      return clog2f(clog2f(side) + 1);
   endfunction

endpackage

// File: rtl/tree_broadcaster_if.sv
// Request side of the broadcaster: valid/ready handshake carrying either a
// scalar or a corner tile plus its starting level.
interface tree_broadcaster_if #(
   parameter int unsigned IMGSIDELENGTH  = 64,
   parameter int unsigned ADDER_DATASIZE = 16
);
   import tree_bcast_pkg::*;

   localparam int unsigned LVL_W = lvl_w_f(IMGSIDELENGTH);

   logic                                                   bc_in_valid;
   logic                                                   bc_in_ready;
   logic [ADDER_DATASIZE-1:0]                              bc_in_data;
   logic [LVL_W-1:0]                                       bc_in_level;
   logic [IMGSIDELENGTH-1:0][IMGSIDELENGTH-1:0][ADDER_DATASIZE-1:0] bc_tile_in;

   modport master (
      output bc_in_valid, bc_in_data, bc_in_level, bc_tile_in,
      input  bc_in_ready
   );

   modport slave (
      input  bc_in_valid, bc_in_data, bc_in_level, bc_tile_in,
      output bc_in_ready
   );

endinterface

// File: rtl/tree_broadcaster_cell.sv
// One grid pixel: register with async clear and a hold / load / copy-from-parent mux.
module tree_broadcast_cell #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_en_i,
   input  logic         exp_en_i,
   input  logic [W-1:0] load_d_i,
   input  logic [W-1:0] par_d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         q_o <= '0;
      else if (load_en_i) q_o <= load_d_i;
      else if (exp_en_i)  q_o <= par_d_i;
   end

endmodule

// File: rtl/tree_broadcaster.sv
// Expands a scalar or 2^L x 2^L corner tile across the full pixel grid by
// in-place 2x nearest-neighbour upsampling, one level per clock.
module tree_broadcaster
   import tree_bcast_pkg::*;
#(
   parameter int unsigned IMGSIDELENGTH  = 64,
   parameter int unsigned ADDER_DATASIZE = 16
) (
   input  logic clk,
   input  logic rst_n,
   tree_broadcaster_if.slave bc_if,
   output logic [IMGSIDELENGTH-1:0][IMGSIDELENGTH-1:0][ADDER_DATASIZE-1:0] bc_pix_out,
   output logic bc_busy,
   output logic bc_done
);

   localparam int unsigned N     = IMGSIDELENGTH;
   localparam int unsigned LOG2N = log2n_f(IMGSIDELENGTH);
   localparam int unsigned LVL_W = lvl_w_f(IMGSIDELENGTH);

   state_t           state_q, state_d;
   logic [LVL_W-1:0] k_q, k_d;
   logic [LVL_W-1:0] lvl_sat;
   logic [31:0]      k_inc;
   logic             accept;

   logic [ADDER_DATASIZE-1:0] pix_q [N][N];

   assign bc_if.bc_in_ready = (state_q == IDLE) & rst_n;
   assign bc_busy           = (state_q != IDLE);
   assign bc_done           = (state_q == DONE);

   assign accept  = bc_if.bc_in_valid & bc_if.bc_in_ready;
   assign lvl_sat = (32'(bc_if.bc_in_level) > LOG2N) ? LVL_W'(LOG2N) : bc_if.bc_in_level;
   assign k_inc   = 32'(k_q) + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: if (accept) begin
            k_d     = lvl_sat;
            state_d = (32'(lvl_sat) < LOG2N) ? EXPAND : DONE;
         end
         EXPAND: begin
            k_d = LVL_W'(k_inc);
            if (k_inc == LOG2N) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Load region is the 2^L corner; expand region is the 2^(k+1) corner,
   // each pixel copying its parent [x>>1][y>>1] from pre-edge values.
   for (genvar x = 0; x < N; x++) begin : g_x
      for (genvar y = 0; y < N; y++) begin : g_y
         logic                      load_en, exp_en;
         logic [ADDER_DATASIZE-1:0] load_d;

         assign load_en = accept && ((32'(x) >> lvl_sat) == 0) && ((32'(y) >> lvl_sat) == 0);
         assign exp_en  = (state_q == EXPAND) && ((32'(x) >> k_inc) == 0) && ((32'(y) >> k_inc) == 0);

         if (x == 0 && y == 0) begin : g_origin
            assign load_d = (lvl_sat == '0) ? bc_if.bc_in_data : bc_if.bc_tile_in[x][y];
         end else begin : g_other
            assign load_d = bc_if.bc_tile_in[x][y];
         end

         tree_broadcast_cell #(.W(ADDER_DATASIZE)) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_en_i (load_en),
            .exp_en_i  (exp_en),
            .load_d_i  (load_d),
            .par_d_i   (pix_q[x/2][y/2]),
            .q_o       (pix_q[x][y])
         );

         assign bc_pix_out[x][y] = pix_q[x][y];
      end
   end

endmodule

// File: tb/tb_tree_broadcaster.sv
// Directed bench for tree_broadcaster: an 8x8 and a 64x64 instance sharing clock and reset.
module tb_tree_broadcaster;
   import tree_bcast_pkg::*;

   typedef logic [7:0][7:0][15:0]   g8_t;
   typedef logic [63:0][63:0][15:0] g64_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tree_broadcaster_if #(.IMGSIDELENGTH(8),  .ADDER_DATASIZE(16)) a_if ();
   tree_broadcaster_if #(.IMGSIDELENGTH(64), .ADDER_DATASIZE(16)) b_if ();

   g8_t  a_pix;
   g64_t b_pix;
   logic a_busy, a_done, b_busy, b_done;

   tree_broadcaster #(.IMGSIDELENGTH(8), .ADDER_DATASIZE(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bc_if(a_if.slave),
      .bc_pix_out(a_pix), .bc_busy(a_busy), .bc_done(a_done)
   );

   tree_broadcaster #(.IMGSIDELENGTH(64), .ADDER_DATASIZE(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bc_if(b_if.slave),
      .bc_pix_out(b_pix), .bc_busy(b_busy), .bc_done(b_done)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int a_done_cnt = 0;
   int b_done_cnt = 0;

   always @(posedge clk) begin
      if (a_done) a_done_cnt++;
      if (b_done) b_done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: every pixel equals tile[x >> (LOG2N-L)][y >> (LOG2N-L)].
   function automatic int bad8(input int L, input g8_t t);
      int b = 0;
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++)
            if (a_pix[x][y] !== t[x >> (3 - L)][y >> (3 - L)]) b++;
      return b;
   endfunction

   function automatic int bad64(input int L, input g64_t t);
      int b = 0;
      for (int x = 0; x < 64; x++)
         for (int y = 0; y < 64; y++)
            if (b_pix[x][y] !== t[x >> (6 - L)][y >> (6 - L)]) b++;
      return b;
   endfunction

   task automatic run8(input int L, input logic [15:0] d, input g8_t t,
                       output int lat, output int busy_cyc);
      int w = 0;
      a_if.bc_in_level = L[1:0];
      a_if.bc_in_data  = d;
      a_if.bc_tile_in  = t;
      a_if.bc_in_valid = 1'b1;
      while (!a_if.bc_in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) chk("a_ready_wait", 64'(a_if.bc_in_ready), 64'd1);
      tick();
      a_if.bc_in_valid = 1'b0;
      lat = 0;
      busy_cyc = int'(a_busy);
      while (!a_done && lat < 50) begin tick(); lat++; busy_cyc += int'(a_busy); end
   endtask

   task automatic run64(input int L, input logic [15:0] d, input g64_t t,
                        output int lat, output int busy_cyc);
      int w = 0;
      b_if.bc_in_level = L[2:0];
      b_if.bc_in_data  = d;
      b_if.bc_tile_in  = t;
      b_if.bc_in_valid = 1'b1;
      while (!b_if.bc_in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) chk("b_ready_wait", 64'(b_if.bc_in_ready), 64'd1);
      tick();
      b_if.bc_in_valid = 1'b0;
      lat = 0;
      busy_cyc = int'(b_busy);
      while (!b_done && lat < 50) begin tick(); lat++; busy_cyc += int'(b_busy); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      g8_t  t8, z8;
      g64_t t64, z64;
      int   lat, bc, dcnt, acc, done_j, rd_all;
      logic rdy_b;

      z8  = '0;
      z64 = '0;
      rst_n = 1'b0;
      a_if.bc_in_valid = 1'b0; a_if.bc_in_data = '0; a_if.bc_in_level = '0; a_if.bc_tile_in = '0;
      b_if.bc_in_valid = 1'b0; b_if.bc_in_data = '0; b_if.bc_in_level = '0; b_if.bc_tile_in = '0;
      tick(); tick(); tick();

      // Reset state
      chk("rst_ready", 64'(a_if.bc_in_ready), 64'd0);
      chk("rst_busy",  64'(a_busy), 64'd0);
      chk("rst_done",  64'(a_done), 64'd0);
      chk("rst_grid",  64'(bad8(0, z8)), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("a_ready_after_rst", 64'(a_if.bc_in_ready), 64'd1);
      chk("b_ready_after_rst", 64'(b_if.bc_in_ready), 64'd1);

      // Reset mid-EXPAND: L=0, 0x00AB, two expand edges then reset
      a_if.bc_in_level = 2'd0;
      a_if.bc_in_data  = 16'h00AB;
      a_if.bc_in_valid = 1'b1;
      tick();
      a_if.bc_in_valid = 1'b0;
      chk("mid_busy", 64'(a_busy), 64'd1);
      tick(); tick();
      chk("mid_pix_in",  64'(a_pix[3][3]), 64'h00AB);
      chk("mid_pix_out", 64'(a_pix[4][4]), 64'h0000);
      dcnt = a_done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_grid",  64'(bad8(0, z8)), 64'd0);
      chk("mid_rst_busy",  64'(a_busy), 64'd0);
      chk("mid_rst_ready", 64'(a_if.bc_in_ready), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rel_ready", 64'(a_if.bc_in_ready), 64'd1);
      chk("mid_no_done",   64'(a_done_cnt), 64'(dcnt));
      chk("mid_rel_busy",  64'(a_busy), 64'd0);

      // Scalar broadcast on 64x64
      t64 = '0;
      t64[0][0] = 16'h1234;
      run64(0, 16'h1234, z64, lat, bc);
      chk("b_scalar_lat",  64'(lat), 64'd6);
      chk("b_scalar_busy", 64'(bc), 64'd7);
      chk("b_scalar_grid", 64'(bad64(0, t64)), 64'd0);
      tick();
      chk("b_after_ready", 64'(b_if.bc_in_ready), 64'd1);
      chk("b_after_done",  64'(b_done), 64'd0);

      // Tile expand, L=1, outside-corner tile entries are junk
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++) t8[x][y] = 16'($urandom);
      t8[0][0] = 16'd1; t8[1][0] = 16'd2; t8[0][1] = 16'd3; t8[1][1] = 16'd4;
      run8(1, 16'hDEAD, t8, lat, bc);
      chk("tile_lat",  64'(lat), 64'd2);
      chk("tile_grid", 64'(bad8(1, t8)), 64'd0);
      chk("tile_q00",  64'(a_pix[3][3]), 64'd1);
      chk("tile_q10",  64'(a_pix[5][2]), 64'd2);
      chk("tile_q01",  64'(a_pix[2][5]), 64'd3);
      chk("tile_q11",  64'(a_pix[7][4]), 64'd4);

      // Full-level load, L=3 on 8x8
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++) t8[x][y] = 16'($urandom);
      run8(3, 16'h0000, t8, lat, bc);
      chk("full8_lat",  64'(lat), 64'd0);
      chk("full8_grid", 64'(bad8(3, t8)), 64'd0);

      // Saturating level, L=7 on 64x64 behaves as L=6
      for (int x = 0; x < 64; x++)
         for (int y = 0; y < 64; y++) t64[x][y] = 16'($urandom);
      run64(7, 16'h0000, t64, lat, bc);
      chk("sat64_lat",  64'(lat), 64'd0);
      chk("sat64_grid", 64'(bad64(6, t64)), 64'd0);

      // Busy-drop: valid held high with changing data
      tick();
      t8 = '0;
      t8[0][0] = 16'h1111;
      a_if.bc_in_level = 2'd0;
      a_if.bc_in_data  = 16'h1111;
      a_if.bc_in_valid = 1'b1;
      tick();
      a_if.bc_in_data = 16'h2001;
      acc = 0;
      done_j = 0;
      for (int j = 1; j <= 20; j++) begin
         rdy_b = a_if.bc_in_ready;
         tick();
         if (a_done && done_j == 0) begin
            done_j = j;
            chk("drop_grid_first", 64'(bad8(0, t8)), 64'd0);
         end
         if (rdy_b) begin acc = j; break; end
         a_if.bc_in_data = 16'h2000 + 16'(j + 1);
      end
      a_if.bc_in_valid = 1'b0;
      chk("drop_done_edge", 64'(done_j), 64'd3);
      chk("drop_accept_edge", 64'(acc), 64'd5);
      lat = 0;
      while (!a_done && lat < 50) begin tick(); lat++; end
      chk("drop_second_lat", 64'(lat), 64'd3);
      t8[0][0] = 16'h2005;
      chk("drop_grid_second", 64'(bad8(0, t8)), 64'd0);

      // Idle hold: valid low, inputs wiggle, grid must not move
      tick();
      dcnt = a_done_cnt;
      rd_all = 1;
      for (int i = 0; i < 10; i++) begin
         a_if.bc_in_data  = 16'($urandom);
         a_if.bc_in_level = 2'($urandom);
         for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) a_if.bc_tile_in[x][y] = 16'($urandom);
         tick();
         if (a_if.bc_in_ready !== 1'b1) rd_all = 0;
      end
      chk("idle_ready", 64'(rd_all), 64'd1);
      chk("idle_no_done", 64'(a_done_cnt), 64'(dcnt));
      chk("idle_grid", 64'(bad8(0, t8)), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
